// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: encodings and helpers shared by the AXI RAM read and write front ends.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

  // Limit a requested beat size to what the data bus can carry.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_ram_rd_skid.sv
// axi_ram_rd_skid: two-entry registered skid buffer with a registered upstream ready.
// The upstream ready is a flop, so the downstream ready never reaches it combinationally.
module axi_ram_rd_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push    = s_valid && ready_q;
  assign pop     = (count != 2'd0) && m_ready;
  assign s_ready = ready_q;
  assign m_valid = (count != 2'd0);
  assign m_data  = mem[head];

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + 2'd1;
    if (pop && !push) count_next = count - 2'd1;
  end

  // Pointers, occupancy and the registered "room for one more" flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
    end
  end

  // Payload storage; contents are meaningless while the slot is empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= s_data;
  end

endmodule

// File: rtl/axi_ram_rd_if.sv
// axi_ram_rd_if: AXI4 read-channel slave front end for on-chip RAM.
// Expands each AR burst into per-beat RAM read commands and returns RAM
// read data on the R channel through a two-entry skid buffer.
module axi_ram_rd_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int ARUSER_ENABLE = 0,
  parameter int ARUSER_WIDTH  = 1,
  parameter int RUSER_ENABLE  = 0,
  parameter int RUSER_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,

  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,

  output logic [ID_WIDTH-1:0]     ram_rd_cmd_id,
  output logic [ADDR_WIDTH-1:0]   ram_rd_cmd_addr,
  output logic                    ram_rd_cmd_lock,
  output logic [3:0]              ram_rd_cmd_cache,
  output logic [2:0]              ram_rd_cmd_prot,
  output logic [3:0]              ram_rd_cmd_qos,
  output logic [3:0]              ram_rd_cmd_region,
  output logic [ARUSER_WIDTH-1:0] ram_rd_cmd_auser,
  output logic                    ram_rd_cmd_en,
  output logic                    ram_rd_cmd_last,
  input  logic                    ram_rd_cmd_ready,

  input  logic [ID_WIDTH-1:0]     ram_rd_resp_id,
  input  logic [DATA_WIDTH-1:0]   ram_rd_resp_data,
  input  logic                    ram_rd_resp_last,
  input  logic [RUSER_WIDTH-1:0]  ram_rd_resp_user,
  input  logic                    ram_rd_resp_valid,
  output logic                    ram_rd_resp_ready
);

  import axi_ram_pkg::*;

  localparam int SIZE_MAX  = $clog2(STRB_WIDTH);
  localparam int PAYLOAD_W = ID_WIDTH + DATA_WIDTH + 1 + RUSER_WIDTH;

  if ((STRB_WIDTH < 1) || ((STRB_WIDTH & (STRB_WIDTH - 1)) != 0) ||
      ((DATA_WIDTH % STRB_WIDTH) != 0)) begin : g_strb_check
    $error("axi_ram_rd_if: STRB_WIDTH must be a power of two that divides DATA_WIDTH");
  end

  rd_state_t                 state, state_next;
  logic                      arready_q, arready_next;
  logic                      cmd_valid_q, cmd_valid_next;
  logic                      last_q, last_next;
  logic [7:0]                count_q, count_next;
  logic [2:0]                size_q, size_next;
  logic [1:0]                burst_q, burst_next;
  logic [ID_WIDTH-1:0]       id_q, id_next;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_next;
  logic                      lock_q, lock_next;
  logic [3:0]                cache_q, cache_next;
  logic [2:0]                prot_q, prot_next;
  logic [3:0]                qos_q, qos_next;
  logic [3:0]                region_q, region_next;
  logic [ARUSER_WIDTH-1:0]   auser_q, auser_next;
  logic [ADDR_WIDTH-1:0]     stride;

  // Byte step between beats; the address simply wraps at the top of the space.
  assign stride = ADDR_WIDTH'(1) << size_q;

  // Burst expansion: next state, next command fields and next arready.
  always_comb begin
    state_next     = state;
    arready_next   = arready_q;
    cmd_valid_next = cmd_valid_q;
    last_next      = last_q;
    count_next     = count_q;
    size_next      = size_q;
    burst_next     = burst_q;
    id_next        = id_q;
    addr_next      = addr_q;
    lock_next      = lock_q;
    cache_next     = cache_q;
    prot_next      = prot_q;
    qos_next       = qos_q;
    region_next    = region_q;
    auser_next     = auser_q;

    case (state)
      ST_IDLE: begin
        arready_next = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          id_next        = s_axi_arid;
          addr_next      = s_axi_araddr;
          lock_next      = s_axi_arlock;
          cache_next     = s_axi_arcache;
          prot_next      = s_axi_arprot;
          qos_next       = s_axi_arqos;
          region_next    = s_axi_arregion;
          auser_next     = s_axi_aruser;
          count_next     = s_axi_arlen;
          size_next      = clamp_size(s_axi_arsize, 3'(SIZE_MAX));
          burst_next     = s_axi_arburst;
          cmd_valid_next = 1'b1;
          last_next      = (s_axi_arlen == 8'd0);
          arready_next   = 1'b0;
          state_next     = ST_BURST;
        end
      end
      ST_BURST: begin
        arready_next = 1'b0;
        if (cmd_valid_q && ram_rd_cmd_ready) begin
          // WRAP bursts are walked like INCR; only FIXED holds the address.
          if (burst_q != BURST_FIXED) addr_next = addr_q + stride;
          if (count_q == 8'd0) begin
            cmd_valid_next = 1'b0;
            arready_next   = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            count_next = count_q - 8'd1;
            last_next  = (count_q == 8'd1);
          end
        end
      end
      default: begin
        state_next     = ST_IDLE;
        cmd_valid_next = 1'b0;
        arready_next   = 1'b0;
      end
    endcase
  end

  // Control state; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      arready_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      arready_q   <= arready_next;
      cmd_valid_q <= cmd_valid_next;
    end
  end

  // Command fields; only meaningful while cmd_valid_q is set.
  always_ff @(posedge clk) begin
    last_q   <= last_next;
    count_q  <= count_next;
    size_q   <= size_next;
    burst_q  <= burst_next;
    id_q     <= id_next;
    addr_q   <= addr_next;
    lock_q   <= lock_next;
    cache_q  <= cache_next;
    prot_q   <= prot_next;
    qos_q    <= qos_next;
    region_q <= region_next;
    auser_q  <= auser_next;
  end

  assign s_axi_arready     = arready_q;
  assign ram_rd_cmd_en     = cmd_valid_q;
  assign ram_rd_cmd_last   = last_q;
  assign ram_rd_cmd_id     = id_q;
  assign ram_rd_cmd_addr   = addr_q;
  assign ram_rd_cmd_lock   = lock_q;
  assign ram_rd_cmd_cache  = cache_q;
  assign ram_rd_cmd_prot   = prot_q;
  assign ram_rd_cmd_qos    = qos_q;
  assign ram_rd_cmd_region = region_q;
  assign ram_rd_cmd_auser  = (ARUSER_ENABLE != 0) ? auser_q : '0;

  logic [PAYLOAD_W-1:0]   resp_payload;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [RUSER_WIDTH-1:0] r_user_raw;

  // ID, last and user come from the RAM return, not from the issued command.
  assign resp_payload = {ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last, ram_rd_resp_user};

  axi_ram_rd_skid #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (resp_payload),
    .s_valid (ram_rd_resp_valid),
    .s_ready (ram_rd_resp_ready),
    .m_data  (r_payload),
    .m_valid (s_axi_rvalid),
    .m_ready (s_axi_rready)
  );

  assign {s_axi_rid, s_axi_rdata, s_axi_rlast, r_user_raw} = r_payload;
  assign s_axi_ruser = (RUSER_ENABLE != 0) ? r_user_raw : '0;
  assign s_axi_rresp = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_rd_if.sv
// tb_axi_ram_rd_if: directed bench for the AXI RAM read front end with a
// behavioural RAM that answers each command one cycle later.
module tb_axi_ram_rd_if;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  s_axi_arid;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arlock;
  logic [3:0]  s_axi_arcache;
  logic [2:0]  s_axi_arprot;
  logic [3:0]  s_axi_arqos;
  logic [3:0]  s_axi_arregion;
  logic [0:0]  s_axi_aruser;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [0:0]  s_axi_ruser;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  ram_rd_cmd_id;
  logic [15:0] ram_rd_cmd_addr;
  logic        ram_rd_cmd_lock;
  logic [3:0]  ram_rd_cmd_cache;
  logic [2:0]  ram_rd_cmd_prot;
  logic [3:0]  ram_rd_cmd_qos;
  logic [3:0]  ram_rd_cmd_region;
  logic [0:0]  ram_rd_cmd_auser;
  logic        ram_rd_cmd_en;
  logic        ram_rd_cmd_last;
  logic        ram_rd_cmd_ready;
  logic [7:0]  ram_rd_resp_id;
  logic [31:0] ram_rd_resp_data;
  logic        ram_rd_resp_last;
  logic [0:0]  ram_rd_resp_user;
  logic        ram_rd_resp_valid;
  logic        ram_rd_resp_ready;

  axi_ram_rd_if dut (
    .clk               (clk),
    .rst               (rst),
    .s_axi_arid        (s_axi_arid),
    .s_axi_araddr      (s_axi_araddr),
    .s_axi_arlen       (s_axi_arlen),
    .s_axi_arsize      (s_axi_arsize),
    .s_axi_arburst     (s_axi_arburst),
    .s_axi_arlock      (s_axi_arlock),
    .s_axi_arcache     (s_axi_arcache),
    .s_axi_arprot      (s_axi_arprot),
    .s_axi_arqos       (s_axi_arqos),
    .s_axi_arregion    (s_axi_arregion),
    .s_axi_aruser      (s_axi_aruser),
    .s_axi_arvalid     (s_axi_arvalid),
    .s_axi_arready     (s_axi_arready),
    .s_axi_rid         (s_axi_rid),
    .s_axi_rdata       (s_axi_rdata),
    .s_axi_rresp       (s_axi_rresp),
    .s_axi_rlast       (s_axi_rlast),
    .s_axi_ruser       (s_axi_ruser),
    .s_axi_rvalid      (s_axi_rvalid),
    .s_axi_rready      (s_axi_rready),
    .ram_rd_cmd_id     (ram_rd_cmd_id),
    .ram_rd_cmd_addr   (ram_rd_cmd_addr),
    .ram_rd_cmd_lock   (ram_rd_cmd_lock),
    .ram_rd_cmd_cache  (ram_rd_cmd_cache),
    .ram_rd_cmd_prot   (ram_rd_cmd_prot),
    .ram_rd_cmd_qos    (ram_rd_cmd_qos),
    .ram_rd_cmd_region (ram_rd_cmd_region),
    .ram_rd_cmd_auser  (ram_rd_cmd_auser),
    .ram_rd_cmd_en     (ram_rd_cmd_en),
    .ram_rd_cmd_last   (ram_rd_cmd_last),
    .ram_rd_cmd_ready  (ram_rd_cmd_ready),
    .ram_rd_resp_id    (ram_rd_resp_id),
    .ram_rd_resp_data  (ram_rd_resp_data),
    .ram_rd_resp_last  (ram_rd_resp_last),
    .ram_rd_resp_user  (ram_rd_resp_user),
    .ram_rd_resp_valid (ram_rd_resp_valid),
    .ram_rd_resp_ready (ram_rd_resp_ready)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge; a handshake seen at a falling
  // edge completes at edge cyc+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  id;
    logic        last;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  cmd_t   exp_cmd[$];
  rbeat_t exp_r[$];
  rbeat_t ram_q[$];
  int     cmd_edges[$];
  int     resp_edges[$];
  int     r_edges[$];
  bit     tog_ready = 1'b0;
  bit     saw_full  = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM contents as seen by the bench.
  function automatic logic [31:0] ram_data(input logic [15:0] a, input logic [7:0] id);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a, id, 8'h5A};
  endfunction

  task automatic expect_burst(input logic [7:0] id, input logic [15:0] a0, input int len,
                              input int step, input logic [3:0] cache, input logic [2:0] prot);
    logic [15:0] a;
    a = a0;
    for (int i = 0; i <= len; i++) begin
      exp_cmd.push_back('{a, id, (i == len), cache, prot});
      exp_r.push_back('{id, ram_data(a, id), (i == len)});
      a = a + 16'(step);
    end
  endtask

  // Present one AR and wait for its handshake; call and return just after a rising edge.
  task automatic ar_send(input logic [7:0] id, input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] cache, input logic [2:0] prot, output int hs_edge);
    bit done;
    done           = 1'b0;
    hs_edge        = -1;
    s_axi_arid     = id;
    s_axi_araddr   = a;
    s_axi_arlen    = len;
    s_axi_arsize   = size;
    s_axi_arburst  = burst;
    s_axi_arcache  = cache;
    s_axi_arprot   = prot;
    s_axi_arvalid  = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        hs_edge = cyc + 1;
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_axi_arvalid = 1'b0;
    if (!done) chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_cmd.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drained"}, 64'(exp_cmd.size() + exp_r.size()), 64'd0);
  endtask

  // Behavioural RAM: each accepted command is answered in order, a cycle later.
  initial begin : ram_model
    bit     c_hs;
    bit     r_hs;
    bit     rst_seen;
    rbeat_t b;
    ram_rd_cmd_ready  = 1'b1;
    ram_rd_resp_valid = 1'b0;
    ram_rd_resp_id    = '0;
    ram_rd_resp_data  = '0;
    ram_rd_resp_last  = 1'b0;
    ram_rd_resp_user  = 1'b1;
    forever begin
      @(negedge clk);
      rst_seen = rst;
      c_hs = rst && ram_rd_cmd_en && ram_rd_cmd_ready;
      r_hs = rst && ram_rd_resp_valid && ram_rd_resp_ready;
      b    = '{ram_rd_cmd_id, ram_data(ram_rd_cmd_addr, ram_rd_cmd_id), ram_rd_cmd_last};
      if (r_hs) resp_edges.push_back(cyc + 1);
      @(posedge clk);
      #1;
      if (!rst_seen) begin
        ram_q.delete();
      end else begin
        if (r_hs && ram_q.size() != 0) void'(ram_q.pop_front());
        if (c_hs) ram_q.push_back(b);
      end
      ram_rd_resp_valid = (ram_q.size() != 0);
      if (ram_q.size() != 0) begin
        ram_rd_resp_id   = ram_q[0].id;
        ram_rd_resp_data = ram_q[0].data;
        ram_rd_resp_last = ram_q[0].last;
      end
      ram_rd_cmd_ready = tog_ready ? ~ram_rd_cmd_ready : 1'b1;
    end
  end

  // Command-side monitor.
  initial begin : cmd_mon
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst && ram_rd_cmd_en && ram_rd_cmd_ready) begin
        cmd_edges.push_back(cyc + 1);
        if (exp_cmd.size() == 0) begin
          chk("cmd_extra", 64'(ram_rd_cmd_addr), 64'hFFFF_FFFF);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_addr", 64'(ram_rd_cmd_addr), 64'(e.addr));
          chk("cmd_id", 64'(ram_rd_cmd_id), 64'(e.id));
          chk("cmd_last", 64'(ram_rd_cmd_last), 64'(e.last));
          chk("cmd_cache", 64'(ram_rd_cmd_cache), 64'(e.cache));
          chk("cmd_prot", 64'(ram_rd_cmd_prot), 64'(e.prot));
          chk("cmd_auser", 64'(ram_rd_cmd_auser), 64'd0);
        end
      end
    end
  end

  // R-side monitor: beat contents, hold stability and skid occupancy.
  initial begin : r_mon
    rbeat_t e;
    rbeat_t held;
    bit     held_v;
    int     occ;
    int     hold;
    held_v = 1'b0;
    occ    = 0;
    hold   = 2;
    forever begin
      @(negedge clk);
      if (!rst) begin
        occ    = 0;
        hold   = 2;
        held_v = 1'b0;
      end else begin
        if (hold > 0) begin
          hold--;
        end else begin
          chk("resp_ready", 64'(ram_rd_resp_ready), 64'(occ < 2));
          chk("rvalid_occ", 64'(s_axi_rvalid), 64'(occ > 0));
        end
        if (occ == 2 && !ram_rd_resp_ready) saw_full = 1'b1;
        if (held_v) begin
          chk("r_hold_valid", 64'(s_axi_rvalid), 64'd1);
          chk("r_hold_data", 64'(s_axi_rdata), 64'(held.data));
          chk("r_hold_id", 64'(s_axi_rid), 64'(held.id));
          chk("r_hold_last", 64'(s_axi_rlast), 64'(held.last));
        end
        held_v = s_axi_rvalid && !s_axi_rready;
        held   = '{s_axi_rid, s_axi_rdata, s_axi_rlast};
        if (s_axi_rvalid && s_axi_rready) begin
          r_edges.push_back(cyc + 1);
          if (exp_r.size() == 0) begin
            chk("r_extra", 64'(s_axi_rdata), 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_r.pop_front();
            chk("r_data", 64'(s_axi_rdata), 64'(e.data));
            chk("r_id", 64'(s_axi_rid), 64'(e.id));
            chk("r_last", 64'(s_axi_rlast), 64'(e.last));
            chk("r_resp", 64'(s_axi_rresp), 64'd0);
            chk("r_user", 64'(s_axi_ruser), 64'd0);
          end
        end
        if (ram_rd_resp_valid && ram_rd_resp_ready) occ++;
        if (s_axi_rvalid && s_axi_rready) occ--;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e_ar;
    int e_ar2;
    rst            = 1'b0;
    s_axi_arid     = '0;
    s_axi_araddr   = '0;
    s_axi_arlen    = '0;
    s_axi_arsize   = '0;
    s_axi_arburst  = 2'b01;
    s_axi_arlock   = 1'b0;
    s_axi_arcache  = '0;
    s_axi_arprot   = '0;
    s_axi_arqos    = 4'h5;
    s_axi_arregion = 4'h2;
    s_axi_aruser   = 1'b1;
    s_axi_arvalid  = 1'b0;
    s_axi_rready   = 1'b1;

    // Reset state and arready rising one cycle after release.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_cmd_en", 64'(ram_rd_cmd_en), 64'd0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("rst_resp_ready", 64'(ram_rd_resp_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("arready_pre", 64'(s_axi_arready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("arready_rise", 64'(s_axi_arready), 64'd1);
    @(posedge clk);
    #1;

    // Single beat at 0x0010; checks command and response latency.
    cmd_edges.delete();
    resp_edges.delete();
    r_edges.delete();
    expect_burst(8'h11, 16'h0010, 0, 4, 4'h3, 3'b010);
    ar_send(8'h11, 16'h0010, 8'd0, 3'd2, 2'b01, 4'h3, 3'b010, e_ar);
    wait_drain("single");
    chk("cmd_lat", 64'((cmd_edges.size() > 0) ? cmd_edges[0] - e_ar : -99), 64'd1);
    chk("r_lat", 64'((r_edges.size() > 0 && resp_edges.size() > 0) ? r_edges[0] - resp_edges[0] : -99), 64'd1);

    // INCR, four beats of four bytes.
    expect_burst(8'h22, 16'h0100, 3, 4, 4'hA, 3'b001);
    ar_send(8'h22, 16'h0100, 8'd3, 3'd2, 2'b01, 4'hA, 3'b001, e_ar);
    wait_drain("incr4");

    // FIXED: every beat at the same address.
    expect_burst(8'h23, 16'h0040, 2, 0, 4'h1, 3'b100);
    ar_send(8'h23, 16'h0040, 8'd2, 3'd2, 2'b00, 4'h1, 3'b100, e_ar);
    wait_drain("fixed");

    // arsize=3 on a 32-bit bus steps by 4 bytes.
    expect_burst(8'h24, 16'h0040, 1, 4, 4'h0, 3'b000);
    ar_send(8'h24, 16'h0040, 8'd1, 3'd3, 2'b01, 4'h0, 3'b000, e_ar);
    wait_drain("clamp");

    // WRAP walked as INCR, crossing the top of the address space.
    expect_burst(8'h25, 16'hFFFC, 1, 4, 4'h0, 3'b000);
    ar_send(8'h25, 16'hFFFC, 8'd1, 3'd2, 2'b10, 4'h0, 3'b000, e_ar);
    wait_drain("addr_wrap");

    // Backpressure: toggling command ready and five cycles without rready.
    tog_ready = 1'b1;
    expect_burst(8'h33, 16'h0200, 7, 4, 4'h0, 3'b000);
    ar_send(8'h33, 16'h0200, 8'd7, 3'd2, 2'b01, 4'h0, 3'b000, e_ar);
    repeat (2) @(posedge clk);
    #1;
    saw_full     = 1'b0;
    s_axi_rready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    s_axi_rready = 1'b1;
    chk("bp_full", 64'(saw_full), 64'd1);
    wait_drain("backpressure");
    tog_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back ARs: one-cycle bubble between bursts.
    cmd_edges.delete();
    expect_burst(8'h01, 16'h0300, 1, 4, 4'h0, 3'b000);
    expect_burst(8'h02, 16'h0400, 1, 4, 4'h0, 3'b000);
    ar_send(8'h01, 16'h0300, 8'd1, 3'd2, 2'b01, 4'h0, 3'b000, e_ar);
    ar_send(8'h02, 16'h0400, 8'd1, 3'd2, 2'b01, 4'h0, 3'b000, e_ar2);
    wait_drain("b2b");
    chk("b2b_gap", 64'((cmd_edges.size() >= 4) ? cmd_edges[2] - cmd_edges[1] : -99), 64'd2);

    // Reset in the middle of an eight-beat burst.
    expect_burst(8'h44, 16'h0500, 7, 4, 4'h0, 3'b000);
    ar_send(8'h44, 16'h0500, 8'd7, 3'd2, 2'b01, 4'h0, 3'b000, e_ar);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cmd.delete();
    exp_r.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_cmd_en", 64'(ram_rd_cmd_en), 64'd0);
    chk("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    chk("mid_rst_arready", 64'(s_axi_arready), 64'd0);
    chk("mid_rst_resp_ready", 64'(ram_rd_resp_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_arready_pre", 64'(s_axi_arready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rel_arready_rise", 64'(s_axi_arready), 64'd1);
    repeat (15) @(posedge clk);
    #1;

    // Recovery after the abandoned burst.
    expect_burst(8'h55, 16'h0010, 0, 4, 4'h0, 3'b000);
    ar_send(8'h55, 16'h0010, 8'd0, 3'd2, 2'b01, 4'h0, 3'b000, e_ar);
    wait_drain("recover");
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ram_rd_if.md
# axi_ram_rd_if

AXI4 read-channel slave front end for on-chip RAM: accepts AR bursts, expands each into per-beat RAM read commands, and returns RAM read responses on the R channel through a 2-entry skid buffer. It sits between an AXI interconnect port and the RAM core, alongside the write-channel front end on the same RAM.

## Interface
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 16, byte address width
- STRB_WIDTH, DATA_WIDTH/8, bytes per beat; power of two, DATA_WIDTH divisible by it (elaboration error otherwise)
- ID_WIDTH, 8, AXI ID width
- ARUSER_ENABLE / ARUSER_WIDTH, 0 / 1, propagate aruser to ram_rd_cmd_auser (else drive 0)
- RUSER_ENABLE / RUSER_WIDTH, 0 / 1, propagate ram_rd_resp_user to s_axi_ruser (else drive 0)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- s_axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]  input  ID/ADDR/8/3/2  read address and burst
- s_axi_arlock/arcache/arprot/arqos/arregion/aruser  input  1/4/3/4/4/ARUSER_WIDTH  sideband, captured and forwarded
- s_axi_arvalid  input  1;  s_axi_arready  output  1
- s_axi_rid/rdata/rresp/rlast/ruser  output  ID/DATA/2/1/RUSER_WIDTH  read data; rresp fixed 2'b00
- s_axi_rvalid  output  1;  s_axi_rready  input  1
- ram_rd_cmd_id/addr/lock/cache/prot/qos/region/auser  output  widths as AR  per-beat command fields
- ram_rd_cmd_en  output  1  command valid;  ram_rd_cmd_last  output  1  final beat of burst
- ram_rd_cmd_ready  input  1  RAM accepts command
- ram_rd_resp_id/data/last/user  input  ID/DATA/1/RUSER_WIDTH  RAM read return
- ram_rd_resp_valid  input  1;  ram_rd_resp_ready  output  1

## Operation
- FSM states IDLE, BURST. IDLE: arready_next=1. AR handshake: capture id, addr, sideband, count=arlen, size=min(arsize, log2(STRB_WIDTH)), burst; cmd_valid=1, last=(arlen==0), arready_next=0, go BURST.
- BURST: ram_rd_cmd_en=cmd_valid. On en&&ready: addr += 1<<size unless burst==FIXED (2'b00); WRAP treated as INCR; count-=1; last=(count_next==0). If count was 0: cmd_valid=0, arready_next=1, go IDLE.
- Address increment is ADDR_WIDTH modulo; wraps silently at top of space.
- Response path: ram_rd_resp_* fed into skid; ram_rd_resp_ready is registered "skid has ≥1 free slot next cycle". R outputs come from skid head; rid/rlast/ruser taken from the RAM response, not from the command.
- Beats returned in order; block does not reorder or count responses.
- Reset (rst=0): state IDLE, arready=0, ram_rd_cmd_en=0, rvalid=0, ram_rd_resp_ready=0, skid emptied; data/ID registers not reset. Reset mid-burst abandons remaining beats; no R beats issued afterward.

## Timing
- arready rises 1 cycle after reset release; AR handshake at cycle N → ram_rd_cmd_en at N+1, first addr = araddr.
- One command per cycle when ram_rd_cmd_ready held high; arlen=L burst occupies L+1 cycles of en.
- Last command handshake at cycle M → arready=1 at M+1; next AR handshake earliest M+1, its command at M+2 (one-cycle bubble).
- RAM response accepted at cycle K → s_axi_rvalid at K+1.
- R channel full throughput with rready=1; rready low absorbs up to 2 beats, then resp_ready drops the following cycle. No combinational path rready→ram_rd_resp_ready.
- rvalid, rdata, rid, rlast stable while rvalid && !rready.

## Structure
- Shared package axi_ram_pkg: burst encodings (FIXED/INCR/WRAP), RESP_OKAY, FSM state constants; shared with the write-side front end.
- Sub-module axi_ram_rd_skid: 2-entry registered skid buffer (valid/ready, payload = id+data+last+user), registered ready output.

## Test plan
- Single beat: araddr=0x0010, arlen=0, arsize=2, INCR → one cmd addr 0x0010 last=1; RAM returns 0xDEADBEEF → R beat rdata=0xDEADBEEF, rlast=1, rresp=0.
- INCR burst arlen=3 at 0x0100, arsize=2 → cmd addrs 0x0100,0x0104,0x0108,0x010C, last only on 4th; 4 R beats, rlast on 4th.
- FIXED burst arlen=2 at 0x0040 → three cmds all addr 0x0040; arsize=3 on 32-bit bus clamped to stride 4 for INCR.
- Backpressure: ram_rd_cmd_ready toggled, rready low 5 cycles during 8-beat burst → no beat lost/duplicated, R held stable, resp_ready low after 2 buffered beats.
- Back-to-back ARs (id 0x01 then 0x02) → second cmd starts 2 cycles after first burst's last handshake; rid follows RAM response.
- Reset asserted mid-burst → next cycle en=0, rvalid=0, arready=0; arready=1 one cycle after release.
